// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mips_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between pipeline, arbiter and memory. The slave side is the arbiter;
// the master side is everything around it (pipeline stages and memory model).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: a requester raises req with stable payload and holds it until the
    // one-cycle ack; the arbiter holds mem_* stable from grant until mem_ack.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr,
               mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr,
               mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating IF-starvation counter; sat is high once MAX data wins have been counted.
module arb_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)             cnt_d = '0;
        else if (inc && !sat) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between IF and MEM stages, data-first.
// Define MEM_ARB_STARVE_EN to let IF win after STARVE_MAX consecutive losses.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus,
    output arb_state_e         dbg_state_o
);
    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              force_if;
    logic              grant_i, grant_d;
    logic              if_ack, dm_ack;

    if (STARVE_MAX < 1) begin : g_bad_cfg
        $error("STARVE_MAX must be at least 1");
    end

`ifdef MEM_ARB_STARVE_EN
    logic starve_sat;

    arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_d && bus.if_req),
        .clr   (grant_i),
        .sat   (starve_sat)
    );

    assign force_if = starve_sat;
`else
    assign force_if = 1'b0;
`endif

    // State and the registered memory-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.dm_req && !(force_if && bus.if_req)) state_d = BUSY_D;
                else if (bus.if_req)                         state_d = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_i     = (state_q == IDLE) && (state_d == BUSY_I);
        grant_d     = (state_q == IDLE) && (state_d == BUSY_D);
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grant_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
        end else if (grant_i) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.if_addr;
        end else if (state_q != IDLE && bus.mem_ack) begin
            mem_req_d = 1'b0;
        end
        // An ack arriving in IDLE belongs to no one and is dropped here.
        if_ack = (state_q == BUSY_I) && bus.mem_ack;
        dm_ack = (state_q == BUSY_D) && bus.mem_ack;
    end

    assign bus.if_ack    = if_ack;
    assign bus.dm_ack    = dm_ack;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;
    assign bus.stall     = (bus.if_req && !if_ack) || (bus.dm_req && !dm_ack);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign dbg_state_o   = state_q;
endmodule
